// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase controller: NS/EW lamps, per-phase countdown,
// emergency all-red and night flashing-yellow modes.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned GREEN_T  = 13,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emerg,
  input  logic       night,
  output logic [4:0] countdown_time,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  generate
    if (TICK_DIV < 2 || GREEN_T < 1 || GREEN_T > 16 || YELLOW_T < 1 ||
        YELLOW_T > 16 || ALLRED_T < 1 || ALLRED_T > 16) begin : g_bad_param
      $fatal(1, "traffic_light_ctrl: TICK_DIV must be >=2 and phase lengths 1..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_AR_A  = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_AR_B  = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_EMERG = 3'd6,
    S_NIGHT = 3'd7
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_div;
  logic               r_tick;
  logic               r_flash;
  logic [2:0]         r_ns;
  logic [2:0]         r_ew;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [DIV_W-1:0]   w_div_nx;
  logic               w_tick_nx;
  logic               w_flash_nx;
  logic [2:0]         w_ns_nx;
  logic [2:0]         w_ew_nx;
  logic               w_div_clr;
  logic               w_div_wrap;

  // Normal-mode phase order.
  function automatic state_t next_phase(input state_t s);
    case (s)
      S_AR_A:  next_phase = S_NS_G;
      S_NS_G:  next_phase = S_NS_Y;
      S_NS_Y:  next_phase = S_AR_B;
      S_AR_B:  next_phase = S_EW_G;
      S_EW_G:  next_phase = S_EW_Y;
      default: next_phase = S_AR_A;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      S_NS_G, S_EW_G: phase_len = CNT_W'(GREEN_T);
      S_NS_Y, S_EW_Y: phase_len = CNT_W'(YELLOW_T);
      default:        phase_len = CNT_W'(ALLRED_T);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_AR_A;
      r_cnt   <= CNT_W'(ALLRED_T);
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_flash <= 1'b1;
      r_ns    <= LAMP_R;
      r_ew    <= LAMP_R;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_div   <= w_div_nx;
      r_tick  <= w_tick_nx;
      r_flash <= w_flash_nx;
      r_ns    <= w_ns_nx;
      r_ew    <= w_ew_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_flash_nx = r_flash;
    w_ns_nx    = LAMP_R;
    w_ew_nx    = LAMP_R;

    if (emerg) begin
      w_state_nx = S_EMERG;
      w_cnt_nx   = '0;
    end else if (night) begin
      w_state_nx = S_NIGHT;
      w_cnt_nx   = '0;
      if (r_state != S_NIGHT) begin
        w_flash_nx = 1'b1;
      end else if (r_tick) begin
        w_flash_nx = ~r_flash;
      end
    end else if (r_state == S_EMERG || r_state == S_NIGHT) begin
      w_state_nx = S_AR_A;
      w_cnt_nx   = CNT_W'(ALLRED_T);
    end else if (r_tick) begin
      if (r_cnt > CNT_W'(1)) begin
        w_cnt_nx = r_cnt - CNT_W'(1);
      end else begin
        w_state_nx = next_phase(r_state);
        w_cnt_nx   = phase_len(w_state_nx);
      end
    end

    // Lamps follow the upcoming state so they register alongside it.
    case (w_state_nx)
      S_NS_G:  w_ns_nx = LAMP_G;
      S_NS_Y:  w_ns_nx = LAMP_Y;
      S_EW_G:  w_ew_nx = LAMP_G;
      S_EW_Y:  w_ew_nx = LAMP_Y;
      S_NIGHT: begin
        w_ns_nx = w_flash_nx ? LAMP_Y : LAMP_OFF;
        w_ew_nx = w_flash_nx ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase

    // Divider restarts whenever EMERG or NIGHT is entered or left.
    w_div_clr  = ((w_state_nx == S_EMERG) != (r_state == S_EMERG)) ||
                 ((w_state_nx == S_NIGHT) != (r_state == S_NIGHT));
    w_div_wrap = (r_div == DIV_W'(TICK_DIV - 1));
    w_div_nx   = (w_div_clr || w_div_wrap) ? '0 : r_div + DIV_W'(1);
    w_tick_nx  = w_div_wrap && !w_div_clr;
  end

  assign countdown_time = r_cnt;
  assign ns_light       = r_ns;
  assign ew_light       = r_ew;
  assign tick           = r_tick;

endmodule
